// File: rtl/mimo_pkg.sv
// Shared constants and index helpers for the K-best MIMO detector input stage.
//   WL_DEF / N_DEF  : default word length and real dimension
//   tri_size(n)     : number of upper-triangle entries, n(n+1)/2
//   gadd(r, n)      : packed word offset of row r's diagonal element
//   frame_len(n, f) : words per frame for full-R (f=1) or triangle-only (f=0)
package mimo_pkg;

    localparam int WL_DEF = 16;
    localparam int N_DEF  = 8;

    function automatic int tri_size(input int n);
        return n * (n + 1) / 2;
    endfunction

    // Rows 0..r-1 occupy n, n-1, ... words, so row r starts at r*n - r(r-1)/2.
    function automatic int gadd(input int r, input int n);
        return r * n - r * (r - 1) / 2;
    endfunction

    function automatic int frame_len(input int n, input bit full_r);
        return full_r ? (n * n + n) : (tri_size(n) + n);
    endfunction

    localparam int T_DEF      = tri_size(N_DEF);
    localparam int L_FULL_DEF = frame_len(N_DEF, 1'b1);
    localparam int L_TRI_DEF  = frame_len(N_DEF, 1'b0);

endpackage

// File: rtl/mimo_frame_bank.sv
// One frame buffer: T packed R words followed by N Y words.
//   clk   : clock, rising edge
//   clr   : synchronous clear of all storage
//   we    : write enable for word widx
//   widx  : packed word index, 0..T-1 for R, T..T+N-1 for Y
//   wdata : word to store verbatim
//   rmat  : flat upper triangle, word 0 in the low bits
//   yarr  : flat receive vector, Y[0] in the low bits
module mimo_frame_bank
    import mimo_pkg::*;
#(
    parameter  int WL = WL_DEF,
    parameter  int N  = N_DEF,
    localparam int T  = tri_size(N),
    localparam int D  = T + N,
    localparam int IW = $clog2(D)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            we,
    input  logic [IW-1:0]   widx,
    input  logic [WL-1:0]   wdata,
    output logic [T*WL-1:0] rmat,
    output logic [N*WL-1:0] yarr
);

    logic [D-1:0][WL-1:0] mem;

    always_ff @(posedge clk) begin
        if (clr)
            mem <= '0;
        else if (we)
            mem[widx] <= wdata;
    end

    assign rmat = mem[T-1:0];
    assign yarr = mem[D-1:T];

endmodule

// File: rtl/mimo_frame_loader.sv
// Double-buffered frame loader: packs a streamed R (full or triangle) and Y
// into two banks so the detector reads a stable frame while the next loads.
//   clk, rst            : clock, synchronous active-low reset
//   in_valid/in_ready   : input word handshake; in_data word, in_last frame end
//   out_valid/out_ready : frame handshake toward the detector
//   Rmat, Yarr          : packed triangle and receive vector of the read bank
//   frame_err           : one-cycle pulse after a malformed frame ends
//   frame_cnt           : frames consumed, wraps at 2^16
module mimo_frame_loader
    import mimo_pkg::*;
#(
    parameter  int WL     = WL_DEF,
    parameter  int N      = N_DEF,
    parameter  bit FULL_R = 1'b1,
    localparam int T      = tri_size(N),
    localparam int L      = frame_len(N, FULL_R),
    localparam int IW     = $clog2(T + N),
    localparam int RW     = $clog2(N + 1),
    localparam int CW     = $clog2(L + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WL-1:0]   in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [T*WL-1:0] Rmat,
    output logic [N*WL-1:0] Yarr,
    output logic            frame_err,
    output logic [15:0]     frame_cnt
);

    // row == N marks the Y section; col then doubles as the Y index.
    logic [RW-1:0] row, col, nrow;
    logic [CW-1:0] wcnt;
    logic [1:0]    full;
    logic          wr_bank, rd_bank;
    logic          acc, in_y, store, at_end, commit, bad, consume;
    logic [IW-1:0] widx;

    logic [1:0][T*WL-1:0] rmat_b;
    logic [1:0][N*WL-1:0] yarr_b;

    // Gating with rst keeps in_ready low during the reset cycles themselves.
    assign in_ready  = rst && !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign acc       = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_comb begin
        nrow   = row + 1'b1;
        in_y   = (row == RW'(N));
        store  = in_y || (col >= row);
        // Below-diagonal words yield a meaningless index but are never stored.
        widx   = in_y ? IW'(T + int'(col))
                      : IW'(gadd(int'(row), N) + int'(col) - int'(row));
        at_end = (wcnt == CW'(L - 1));
        commit = acc && at_end && in_last;
        bad    = acc && (in_last != at_end);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row       <= '0;
            col       <= '0;
            wcnt      <= '0;
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            frame_err <= bad;
            if (acc) begin
                if (commit || bad) begin
                    row  <= '0;
                    col  <= '0;
                    wcnt <= '0;
                end else begin
                    wcnt <= wcnt + 1'b1;
                    if (in_y || col != RW'(N - 1)) begin
                        col <= col + 1'b1;
                    end else begin
                        // Triangle rows start on the diagonal; Y starts at 0.
                        row <= nrow;
                        col <= (!FULL_R && nrow != RW'(N)) ? nrow : '0;
                    end
                end
            end
            // Commit and consume always target different banks.
            if (commit) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (consume) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
                frame_cnt     <= frame_cnt + 16'd1;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        mimo_frame_bank #(.WL(WL), .N(N)) u_bank (
            .clk   (clk),
            .clr   (!rst),
            .we    (acc && store && (wr_bank == 1'(b))),
            .widx  (widx),
            .wdata (in_data),
            .rmat  (rmat_b[b]),
            .yarr  (yarr_b[b])
        );
    end

    assign Rmat = rmat_b[rd_bank];
    assign Yarr = yarr_b[rd_bank];

endmodule

// File: doc/mimo_frame_loader.md
# mimo_frame_loader

- Synthesizable, parametrised input stage for the K-best MIMO detector.
- Accepts one word per cycle on a valid/ready stream carrying a channel triangle R (N×N, real-valued) followed by receive vector Y (N words).
- Packs R's upper triangle into the flat `Rmat` layout and Y into `Yarr`, double-buffered, so the detector sees a stable frame while the next one loads.
- Generalises the fixed 8-dimension, file-fed loading to any N, WL and input format.

## Interface

Parameters:
- WL, 16, word length of every R/Y element (signed two's complement)
- N, 8, real dimension (2 × antennas); 8 = 4x4 complex MIMO
- FULL_R, 1, 1: stream carries full N×N R row-major, below-diagonal words discarded; 0: stream carries upper triangle only, row-major

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  loader can accept a word this cycle
- in_data  in  WL  R/Y element
- in_last  in  1  marks the final word of a frame
- out_valid  out  1  `Rmat`/`Yarr` hold a complete frame
- out_ready  in  1  detector takes the frame
- Rmat  out  T*WL  packed upper triangle, T = N(N+1)/2; R[r][c] (c≥r) at word GADD(r-1)+(c-r), GADD(r-1) = r·N − r(r−1)/2
- Yarr  out  N*WL  Y[i] at word i
- frame_err  out  1  one-cycle pulse on a malformed frame
- frame_cnt  out  16  count of frames delivered (wraps at 2^16)

## Operation

- Frame length L = N·N+N (FULL_R=1) or T+N (FULL_R=0); N=8 gives L=72 or 44.
- Write-side counters row, col, and the Y index track the position in the frame.
  - FULL_R=1: col sweeps 0..N−1 each row; words with col<row are accepted but not stored.
  - FULL_R=0: col sweeps row..N−1.
- Two banks, each with a full flag; wr_bank and rd_bank pointers.
- in_ready = !full[wr_bank].
- A word is accepted when in_valid && in_ready and is written to wr_bank at its packed position.
- Frame commit: the accepted word is number L and in_last=1.
  - Set full[wr_bank] and toggle wr_bank.
  - Reset the write counters.
- Error, either case:
  - in_last=1 on word k<L, or word L accepted with in_last=0.
  - Bank is not marked full, counters reset, frame_err pulses for 1 cycle.
  - Partially written bank contents are don't-care.
- out_valid = full[rd_bank].
- Consumption: on out_valid && out_ready:
  - clear full[rd_bank], toggle rd_bank, increment frame_cnt.
- Commit and consumption in the same cycle act on different banks; both take effect.
- Rmat and Yarr are multiplexed from the rd_bank registers.
  - They are stable whenever out_valid=1 and out_ready=0.
- Sign and width: words are stored verbatim, with no arithmetic.
- Reset (rst=0 at a clock edge), including mid-frame:
  - full flags, pointers and counters go to 0.
  - out_valid=0, frame_err=0, frame_cnt=0.
  - All bank storage, and therefore Rmat and Yarr, goes to 0.
  - in_ready is 0 while rst=0 and 1 in the first cycle after release.
  - A partial frame is lost, and the next accepted word is word 1.

## Timing

- Latency: word L accepted at edge t → out_valid=1 after edge t (same cycle as the first cycle after commit), so the detector can take the frame at edge t+1.
- Sustained throughput: one frame per L cycles when out_ready is held at 1; no bubble between frames.
- Backpressure:
  - With both banks full, in_ready=0.
  - in_ready rises the cycle after the out_valid&&out_ready edge.
- frame_err is high exactly one cycle, in the cycle after the offending word is accepted.

## Structure

- Shared package mimo_pkg holds:
  - WL and N defaults
  - T = N(N+1)/2
  - function gadd(r) returning the row offset (replaces the GADD macro)
  - frame-length constants for both FULL_R modes
- Sub-module mimo_frame_bank holds one bank.
  - Inputs: write enable, packed word index, data; synchronous clear.
  - Outputs: the flat Rmat/Yarr vectors.
  - The loader instantiates it twice.
- Top-level logic is the counter/index generator, bank flags and output mux.

## Test plan

- Reset behaviour: hold rst=0 for 3 cycles → out_valid=0, frame_err=0, frame_cnt=0, Rmat=0, in_ready=0; in_ready=1 the cycle after release.
- Basic load (N=8, FULL_R=1): send words 0..71 with in_last on word 71.
  - → out_valid=1 the cycle after the last word is accepted.
  - R[r][c]=8r+c, e.g. Rmat word 8 (R[1][1]) = 9 and word 35 (R[7][7]) = 63.
  - Yarr[0]=64, Yarr[7]=71; after one out_ready pulse frame_cnt=1.
- Backpressure: out_ready=0, stream 3 back-to-back frames.
  - → frames 1–2 accepted; in_ready=0 from the cycle after frame 2's last word.
  - Rmat stays frame 1.
  - One out_ready pulse → frame 2 presented; in_ready returns and frame 3 loads.
- Malformed frames:
  - in_last on word 40 → frame_err pulse, no out_valid.
  - Word 72 without in_last → frame_err pulse.
  - A following correct frame is delivered intact.
- Reset mid-frame: assert rst=0 after word 30, then send a full frame → delivered frame matches the new data only; frame_cnt counts it as 1.
- Triangle mode (FULL_R=0, N=8): 44 words 0..43 → Rmat word i = i for i<36, Yarr[i] = 36+i. Repeat with N=4 and WL=12 → T=10 and L=14 are honoured.
